// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control-word bit map, sequencer modes and status bit indices
package cpu_ctrl_pkg;
  localparam int CW_W = 31;
  localparam logic [CW_W-1:0] FETCH_CW = 31'h0000_0008;
  localparam int PSEL_HI = 30;
  localparam int PSEL_LO = 29;
  localparam int DA_HI   = 28;
  localparam int DA_LO   = 24;
  localparam int SA_HI   = 23;
  localparam int SA_LO   = 19;
  localparam int SB_HI   = 18;
  localparam int SB_LO   = 14;
  localparam int FSEL_HI = 13;
  localparam int FSEL_LO = 9;
  localparam int REGW    = 8;
  localparam int RAMW    = 7;
  localparam int EN_MEM  = 6;
  localparam int EN_ALU  = 5;
  localparam int EN_B    = 4;
  localparam int EN_PC   = 3;
  localparam int BSEL    = 2;
  localparam int PCSEL   = 1;
  localparam int SL      = 0;
  localparam int ST_V  = 4;
  localparam int ST_C  = 3;
  localparam int ST_Z  = 2;
  localparam int ST_N  = 1;
  localparam int ST_ZI = 0;
  typedef enum logic {MODE_FETCH = 1'b0, MODE_EXEC = 1'b1} mode_t;
endpackage

// File: rtl/flag_register.sv
// flag_register: architectural {V,C,Z,N} flags with load enable
//   clock, reset_n : clock and async active-low clear
//   en, d          : load enable and next flag value
//   q              : registered flags
module flag_register (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/exec sequencer gating decoder control words onto the datapath
//   clock, reset_n            : clock and async active-low reset
//   instruction, imem_ready   : instruction memory data and valid
//   dmem_ready                : data memory access complete
//   alu_status                : live ALU flags {V,C,Z,N,ZI}
//   cw_in, next_state_in      : decoder control word and next phase
//   flag_set                  : decoder requests a flag update
//   ir, state, status         : instruction, phase and flags back to decoders
//   fetch, control_word       : imem request and gated datapath control word
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CW_W = cpu_ctrl_pkg::CW_W,
  parameter logic [CW_W-1:0] FETCH_CW = cpu_ctrl_pkg::FETCH_CW
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     instruction,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic [4:0]      alu_status,
  input  logic [CW_W-1:0] cw_in,
  input  logic [1:0]      next_state_in,
  input  logic            flag_set,
  output logic [31:0]     ir,
  output logic [1:0]      state,
  output logic [4:0]      status,
  output logic            fetch,
  output logic [CW_W-1:0] control_word
);
  localparam logic [CW_W-1:0] REGW_MASK = ~(CW_W'(1) << REGW);
  mode_t mode;
  logic stall;
  logic [3:0] flags;
  assign fetch = mode == MODE_FETCH;
  assign stall = !fetch && (cw_in[EN_MEM] || cw_in[RAMW]) && !dmem_ready;
  // only the register write is suppressed while stalled; memory strobes stay up
  assign control_word = fetch ? FETCH_CW : stall ? cw_in & REGW_MASK : cw_in;
  assign status = {flags, alu_status[ST_ZI]};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mode <= MODE_FETCH;
      ir <= '0;
      state <= 2'b00;
    end else if (fetch) begin
      if (imem_ready) begin
        ir <= instruction;
        state <= 2'b00;
        mode <= MODE_EXEC;
      end
    end else if (!stall) begin
      state <= next_state_in;
      mode <= next_state_in == 2'b00 ? MODE_FETCH : MODE_EXEC;
    end
  flag_register u_flags (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (!fetch && flag_set && !stall),
    .d      (alu_status[ST_V:ST_N]),
    .q      (flags)
  );
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-vector bench for control_sequencer
module tb_control_sequencer;
  localparam logic [30:0] FCW = 31'h0000_0008;
  logic        clock = 0;
  logic        reset_n = 1;
  logic [31:0] instruction = '0;
  logic        imem_ready = 0;
  logic        dmem_ready = 0;
  logic [4:0]  alu_status = '0;
  logic [30:0] cw_in = '0;
  logic [1:0]  next_state_in = '0;
  logic        flag_set = 0;
  logic [31:0] ir;
  logic [1:0]  state;
  logic [4:0]  status;
  logic        fetch;
  logic [30:0] control_word;
  int n_chk = 0;
  int n_bad = 0;
  control_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instruction  (instruction),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .alu_status   (alu_status),
    .cw_in        (cw_in),
    .next_state_in(next_state_in),
    .flag_set     (flag_set),
    .ir           (ir),
    .state        (state),
    .status       (status),
    .fetch        (fetch),
    .control_word (control_word)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  initial begin
    #2 reset_n = 0;
    #1;
    chk("rst_fetch", 32'(fetch), 1);
    chk("rst_cw", 32'(control_word), 32'(FCW));
    chk("rst_ir", ir, 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_status", 32'(status), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      chk("wait_fetch", 32'(fetch), 1);
      chk("wait_cw", 32'(control_word), 32'(FCW));
    end
    imem_ready = 1;
    instruction = 32'h5400_0040;
    cw_in = 31'h2000_0002;
    next_state_in = 2'b00;
    @(negedge clock);
    imem_ready = 0;
    #1;
    chk("f1_ir", ir, 32'h5400_0040);
    chk("f1_state", 32'(state), 0);
    chk("f1_fetch", 32'(fetch), 0);
    chk("sc_cw", 32'(control_word), 32'h2000_0002);
    @(negedge clock);
    #1;
    chk("sc_back_fetch", 32'(fetch), 1);
    chk("sc_back_cw", 32'(control_word), 32'(FCW));
    imem_ready = 1;
    instruction = 32'h1234_5678;
    cw_in = 31'h0000_0021;
    next_state_in = 2'b01;
    @(negedge clock);
    instruction = 32'hDEAD_BEEF;
    #1;
    chk("mp_ir", ir, 32'h1234_5678);
    chk("mp_s0", 32'(state), 0);
    chk("mp_f0", 32'(fetch), 0);
    @(negedge clock);
    next_state_in = 2'b10;
    #1;
    chk("mp_s1", 32'(state), 1);
    chk("mp_ir_hold", ir, 32'h1234_5678);
    chk("mp_f1", 32'(fetch), 0);
    @(negedge clock);
    next_state_in = 2'b00;
    #1;
    chk("mp_s2", 32'(state), 2);
    chk("mp_f2", 32'(fetch), 0);
    @(negedge clock);
    imem_ready = 0;
    #1;
    chk("mp_end_fetch", 32'(fetch), 1);
    chk("mp_end_state", 32'(state), 0);
    imem_ready = 1;
    instruction = 32'hAAAA_0001;
    cw_in = 31'h1000_0140;
    next_state_in = 2'b01;
    dmem_ready = 0;
    flag_set = 1;
    alu_status = 5'b11110;
    @(negedge clock);
    imem_ready = 0;
    #1;
    chk("st1_cw", 32'(control_word), 32'h1000_0040);
    chk("st1_state", 32'(state), 0);
    chk("st1_status", 32'(status), 0);
    @(negedge clock);
    #1;
    chk("st2_cw", 32'(control_word), 32'h1000_0040);
    chk("st2_state", 32'(state), 0);
    chk("st2_flags_hold", 32'(status), 0);
    @(negedge clock);
    dmem_ready = 1;
    #1;
    chk("st3_cw", 32'(control_word), 32'h1000_0140);
    chk("st3_state", 32'(state), 0);
    @(negedge clock);
    cw_in = 31'h0000_0021;
    next_state_in = 2'b00;
    flag_set = 0;
    dmem_ready = 0;
    alu_status = 5'b00001;
    #1;
    chk("st_adv_state", 32'(state), 1);
    chk("st_flags", 32'(status), 32'h1F);
    chk("nomem_cw", 32'(control_word), 32'h21);
    @(negedge clock);
    imem_ready = 1;
    instruction = 32'h0000_0777;
    cw_in = 31'h0000_0020;
    next_state_in = 2'b00;
    flag_set = 1;
    alu_status = 5'b10110;
    @(negedge clock);
    imem_ready = 0;
    #1;
    chk("fl_old", 32'(status), 32'h1E);
    @(negedge clock);
    flag_set = 0;
    alu_status = 5'b01101;
    imem_ready = 1;
    instruction = 32'h0000_0888;
    #1;
    chk("fl_new", 32'(status), 32'h17);
    chk("fl_fetch", 32'(fetch), 1);
    @(negedge clock);
    imem_ready = 0;
    alu_status = 5'b11100;
    #1;
    chk("fl_hold_exec", 32'(status), 32'h16);
    chk("fl_exec_fetch", 32'(fetch), 0);
    @(negedge clock);
    imem_ready = 1;
    instruction = 32'hBBBB_0002;
    cw_in = 31'h1000_0080;
    next_state_in = 2'b01;
    dmem_ready = 0;
    #1;
    chk("fl_hold_after", 32'(status), 32'h16);
    @(negedge clock);
    imem_ready = 0;
    #1;
    chk("rs_pre_fetch", 32'(fetch), 0);
    chk("rs_pre_cw", 32'(control_word), 32'h1000_0080);
    chk("rs_pre_ir", ir, 32'hBBBB_0002);
    #1 reset_n = 0;
    #1;
    chk("rs_fetch", 32'(fetch), 1);
    chk("rs_cw", 32'(control_word), 32'(FCW));
    chk("rs_status", 32'(status), 0);
    chk("rs_ir", ir, 0);
    chk("rs_state", 32'(state), 0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Top-level control sequencer for the single-issue datapath.
- Fetches each instruction into an instruction register and steps the 2-bit execution phase (`state`) through which the per-class decoders are indexed; decoders return control word, next phase and K.
- Gates the decoder control word onto the datapath, stalls on data-memory handshakes, and owns the architectural flag register {V,C,Z,N} that feeds conditional-branch decoding.

Parameters:
- CW_W, 31, control word width.
- FETCH_CW, 31'h0000_0008, control word driven during fetch: Psel=00, EN_PC=1, all writes 0.

Ports:
- clock  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- instruction  input  32  instruction memory read data
- imem_ready  input  1  instruction memory data valid this cycle
- dmem_ready  input  1  data memory access complete this cycle
- alu_status  input  5  live ALU flags {V,C,Z,N,ZI}
- cw_in  input  31  control word from selected decoder (bit map below)
- next_state_in  input  2  decoder-requested next phase
- flag_set  input  1  decoder: current instruction updates flags (S-suffix)
- ir  output  32  registered instruction to decoders
- state  output  2  current execution phase to decoders
- status  output  5  {V,C,Z,N registered, ZI live} to decoders
- fetch  output  1  high in FETCH; instruction memory request
- control_word  output  31  gated control word to datapath

Behaviour:
- Control word map: [30:29] Psel, [28:24] DA, [23:19] SA, [18:14] SB, [13:9] Fsel, [8] regW, [7] ramW, [6] EN_MEM, [5] EN_ALU, [4] EN_B, [3] EN_PC, [2] Bsel, [1] PCsel, [0] SL.
- FSM: 2 states, FETCH and EXEC, held in a mode register.
- Reset (async, reset_n=0):
  - mode=FETCH, ir=0, state=00, flags {V,C,Z,N}=0.
  - Outputs immediately: fetch=1, control_word=FETCH_CW.
- FETCH:
  - fetch=1, control_word=FETCH_CW.
  - On a clock edge with imem_ready=1: ir<=instruction, state<=00, mode<=EXEC.
  - imem_ready=0: hold; no register changes.
  - Minimum 1 cycle.
- EXEC:
  - fetch=0, control_word=cw_in except during stall.
  - Mem access this cycle = cw_in[6] | cw_in[7].
  - Stall = mem access & ~dmem_ready. During stall:
    - control_word[8] (regW) forced 0; all other bits pass, so ramW/EN_MEM stay asserted.
    - state, ir, flags, mode hold.
  - Non-stalled edge:
    - If flag_set: {V,C,Z,N}<=alu_status[4:1].
    - If next_state_in==00: mode<=FETCH, state<=00.
    - Else: state<=next_state_in, remain EXEC.
- Single-cycle instruction (next_state_in=00): exactly 1 EXEC cycle.
- PC update is only the decoder's Psel in EXEC; FETCH never changes PC (Psel=00).
- ZI in `status` is combinational alu_status[0], never registered.
- Flag write and branch read in the same cycle: decoders see the old flags; the new value is visible from the next cycle.
- imem_ready asserted during EXEC: ignored.
- dmem_ready asserted with no mem access: ignored.
- Reset mid-instruction: abandoned; restart from FETCH with flags cleared.
- Outputs are combinational from registered mode/state plus cw_in, dmem_ready and alu_status[0] only.

Decomposition:
- Shared package `cpu_ctrl_pkg`:
  - control word bit-index constants (PSEL_HI/LO, REGW, RAMW, EN_MEM, EN_PC, ...)
  - mode encodings MODE_FETCH=1'b0, MODE_EXEC=1'b1
  - FETCH_CW constant
  - status bit indices V=4, C=3, Z=2, N=1, ZI=0
- One sub-module, `flag_register`: 4-bit {V,C,Z,N} with async active-low clear and load enable; sequencer drives enable = EXEC & flag_set & ~stall.

Test Plan:
- Reset and first fetch:
  - Stimulus: reset_n=0, then release; imem_ready=0 for 3 cycles, then 1 with instruction=32'h5400_0040.
  - Required: fetch=1, control_word=FETCH_CW throughout; ir=32'h5400_0040, state=00, fetch=0 on the next cycle.
- Single-cycle instruction:
  - Stimulus: cw_in=31'h2000_0002, next_state_in=00.
  - Required: control_word equals cw_in for exactly one cycle, then FETCH.
- Multi-phase instruction:
  - Stimulus: next_state_in sequence 01, 10, 00.
  - Required: state goes 00→01→10, then FETCH after 3 EXEC cycles.
- Data-memory stall:
  - Stimulus: cw_in with EN_MEM=1, regW=1; dmem_ready=0 for 2 cycles, then 1.
  - Required: control_word[8]=0 for 2 cycles, =1 on the third; state holds; advance after the third cycle.
- Flag update:
  - Stimulus: flag_set=1, alu_status=5'b10110, non-stalled.
  - Required: status[4:1]=4'b1011 the next cycle; with flag_set=0, flags hold while status[0] tracks alu_status[0] live.
- Reset mid-stall:
  - Stimulus: reset_n=0 during an EXEC stall.
  - Required: asynchronously fetch=1, control_word=FETCH_CW, status[4:1]=0, ir=0.
